data_mem: RTL and testbench
===========================

# data_mem

Word-organised data memory for the 5-stage MIPS pipeline, instantiated inside the MEM stage. It decodes the instruction opcode to perform loads (combinational read) and stores (clocked write) at the byte address computed by the ALU. The MEM stage registers the load result on the same clock edge that commits a store.

## Interface
- DEPTH_WORDS, 1024 — number of 32-bit words (4 KiB); must be a power of two.
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  reset, synchronous, active-high.
- addr  input  32  byte address (ALU result).
- data  input  32  store data (value of rt).
- opcode  input  6  MIPS primary opcode of the instruction in MEM.
- out  output  32  load result, combinational.

## Operation
- Storage: DEPTH_WORDS x 32-bit array; word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (address wraps modulo memory size).
- Byte order: little-endian; byte lane k = bits [8k+7:8k], lane = addr[1:0].
- Opcode decode:
  - 6'h23 lw: out = word.
  - 6'h20 lb: out = sign-extended byte at lane addr[1:0].
  - 6'h24 lbu: out = zero-extended byte.
  - 6'h21 lh: out = sign-extended halfword at lane addr[1] (bits [15:0] or [31:16]).
  - 6'h25 lhu: out = zero-extended halfword.
  - 6'h2B sw: word <= data.
  - 6'h28 sb: only the lane addr[1:0] <= data[7:0]; other bytes unchanged.
  - 6'h29 sh: only the half addr[1] <= data[15:0]; other half unchanged.
  - Any other opcode: out = 32'h0, no write.
- Misalignment: lw/sw ignore addr[1:0]; lh/lhu/sh ignore addr[0]. No exception raised.
- out is 32'h0 whenever opcode is a store or non-memory instruction.
- Reset: on a rising edge with RST=1 every word is cleared to 32'h0; a store presented in that same cycle is discarded (reset has priority).

## Timing
- Read latency: zero cycles; out follows addr/opcode/memory contents combinationally.
- Write: committed on rising CLK edge when a store opcode is present and RST=0; visible on out from that edge onward.
- Same-address load/store in one cycle is not possible (single opcode); a load in cycle N+1 after a store in cycle N returns the new data.
- Outputs after reset: out = 32'h0 for any load (memory all zero); out = 32'h0 for non-load opcodes.
- No handshake; one access per cycle, always accepted.

## Configuration
- DATAMEM_SUBWORD_EN defined: byte/halfword ops (lb, lbu, lh, lhu, sb, sh) supported as above.
- Not defined: only lw and sw are decoded; the six sub-word opcodes behave as non-memory (out = 32'h0, no write).

## Test plan
- Reset then lw addr=0x0000_0010 -> out = 32'h0.
- sw addr=0x8, data=32'h8765_4321; next cycle lw addr=0x8 -> out = 32'h8765_4321; lw addr=0xB (misaligned) -> same value.
- After above: lb addr=0xB -> 32'hFFFF_FF87; lbu addr=0xB -> 32'h0000_0087; lh addr=0xA -> 32'hFFFF_8765; lhu addr=0x8 -> 32'h0000_4321 (DATAMEM_SUBWORD_EN defined).
- sb addr=0x9 data=32'hAA; lw addr=0x8 -> 32'h8765_AA21. sh addr=0xA data=32'h1234; lw 0x8 -> 32'h1234_AA21. Without macro: same ops leave word 32'h8765_4321 and lb returns 32'h0.
- Wrap: sw addr=0x0000_1004 data=32'h1 (DEPTH_WORDS=1024) -> lw addr=0x4 returns 32'h1; opcode 6'h00 -> out = 32'h0, no write.
- sw addr=0x20 data=32'hFFFF_FFFF with RST=1 same cycle -> after RST drops, lw 0x20 returns 32'h0.

Source files
------------

// File: rtl/data_mem_if.sv
// Bus bundle between the MEM stage and its data memory: byte address,
// store data, primary opcode and the combinational load result.
interface data_mem_if;
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  opcode;
    logic [31:0] out;

    // The MEM stage drives the request and receives the load result.
    modport master (
        output addr,
        output data,
        output opcode,
        input  out
    );

    // The memory receives the request and returns the load result.
    modport slave (
        input  addr,
        input  data,
        input  opcode,
        output out
    );
endinterface

// File: rtl/data_mem.sv
// Word-organised little-endian data memory for the MEM stage of the MIPS
// pipeline. Loads are combinational and stores commit on the rising edge.
// Build option: define DATAMEM_SUBWORD_EN to decode lb/lbu/lh/lhu/sb/sh.
// Without it only lw/sw are memory operations and the rest read as 0.
module data_mem #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    data_mem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic [31:0]            mem [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] valid;
    logic [AW-1:0]          idx;
    logic [31:0]            rd_word;
    logic                   wr_en;
    logic [31:0]            wr_word;
    logic                   unused_addr;

    // Upper bits wrap away; the word index sits just above the byte lane.
    assign idx         = bus.addr[AW+1:2];
    assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

    // A word never written since reset reads as zero.
    assign rd_word = valid[idx] ? mem[idx] : 32'h0;

`ifdef DATAMEM_SUBWORD_EN
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rd_word[{bus.addr[1:0], 3'b000} +: 8];
    assign rd_half = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
`endif

    // Load result: select and extend the addressed word, byte or half.
    always_comb begin
        // NOTE: default assignment first so no path leaves out undriven (no latch).
        bus.out = 32'h0;
        case (bus.opcode)
            OP_LW:  bus.out = rd_word;
`ifdef DATAMEM_SUBWORD_EN
            OP_LB:  bus.out = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU: bus.out = {24'h0, rd_byte};
            OP_LH:  bus.out = {{16{rd_half[15]}}, rd_half};
            OP_LHU: bus.out = {16'h0, rd_half};
`endif
            default: bus.out = 32'h0;
        endcase
    end

    // Store merge: build the full new word so sub-word stores keep other lanes.
    always_comb begin
        wr_en   = 1'b0;
        wr_word = rd_word;
        case (bus.opcode)
            OP_SW: begin
                wr_en   = 1'b1;
                wr_word = bus.data;
            end
`ifdef DATAMEM_SUBWORD_EN
            OP_SB: begin
                wr_en = 1'b1;
                wr_word[{bus.addr[1:0], 3'b000} +: 8] = bus.data[7:0];
            end
            OP_SH: begin
                wr_en = 1'b1;
                if (bus.addr[1]) wr_word[31:16] = bus.data[15:0];
                else             wr_word[15:0]  = bus.data[15:0];
            end
`endif
            default: begin
                wr_en   = 1'b0;
                wr_word = rd_word;
            end
        endcase
    end

    // Per-word valid flags: reset clears all, a store marks its word.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments for all clocked state.
        if (RST)        valid      <= '0;
        else if (wr_en) valid[idx] <= 1'b1;
    end

    // Storage array: reset has priority and discards a concurrent store.
    always_ff @(posedge CLK) begin
        // NOTE: the array itself is not reset; clearing the valid flags zeroes it logically.
        if (!RST && wr_en) mem[idx] <= wr_word;
    end
endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem. Expected values are
// hand-computed; sub-word expectations follow DATAMEM_SUBWORD_EN.
module tb_data_mem;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    data_mem_if bus ();

    data_mem #(.DEPTH_WORDS(1024)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

`ifdef DATAMEM_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SWL = 6'h2A;
    localparam logic [5:0] OP_SW  = 6'h2B;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        bus.opcode = op;
        bus.addr   = a;
        bus.data   = d;
        #1;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(OP_NOP, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        drive(OP_LW, 32'h0000_0010, 32'h0);
        check("reset_lw", bus.out, 32'h0);
        drive(OP_NOP, 32'h0000_0010, 32'hDEAD_BEEF);
        check("reset_nop", bus.out, 32'h0);

        // Word store / load, misaligned word access
        drive(OP_SW, 32'h8, 32'h8765_4321);
        check("sw_out_zero", bus.out, 32'h0);
        tick();
        drive(OP_LW, 32'h8, 32'h0);
        check("lw_8", bus.out, 32'h8765_4321);
        drive(OP_LW, 32'hB, 32'h0);
        check("lw_b_misaligned", bus.out, 32'h8765_4321);

        // Sub-word loads
        drive(OP_LB, 32'hB, 32'h0);
        check("lb_b", bus.out, SUBWORD ? 32'hFFFF_FF87 : 32'h0);
        drive(OP_LBU, 32'hB, 32'h0);
        check("lbu_b", bus.out, SUBWORD ? 32'h0000_0087 : 32'h0);
        drive(OP_LH, 32'hA, 32'h0);
        check("lh_a", bus.out, SUBWORD ? 32'hFFFF_8765 : 32'h0);
        drive(OP_LHU, 32'h8, 32'h0);
        check("lhu_8", bus.out, SUBWORD ? 32'h0000_4321 : 32'h0);
        drive(OP_LH, 32'h9, 32'h0);
        check("lh_9_ignores_a0", bus.out, SUBWORD ? 32'h0000_4321 : 32'h0);
        drive(OP_LB, 32'h8, 32'h0);
        check("lb_8_positive", bus.out, SUBWORD ? 32'h0000_0021 : 32'h0);

        // Sub-word stores
        drive(OP_SB, 32'h9, 32'hFFFF_FFAA);
        check("sb_out_zero", bus.out, 32'h0);
        tick();
        drive(OP_LW, 32'h8, 32'h0);
        check("lw_after_sb", bus.out, SUBWORD ? 32'h8765_AA21 : 32'h8765_4321);
        drive(OP_SH, 32'hA, 32'hFFFF_1234);
        tick();
        drive(OP_LW, 32'h8, 32'h0);
        check("lw_after_sh", bus.out, SUBWORD ? 32'h1234_AA21 : 32'h8765_4321);
        drive(OP_LB, 32'h9, 32'h0);
        check("lb_9_after_sb", bus.out, SUBWORD ? 32'hFFFF_FFAA : 32'h0);
        drive(OP_SH, 32'h1, 32'h0000_5678);
        tick();
        drive(OP_LW, 32'h8, 32'h0);
        check("lw_other_word_after_sh", bus.out, SUBWORD ? 32'h1234_AA21 : 32'h8765_4321);
        drive(OP_LW, 32'h0, 32'h0);
        check("lw_0_after_sh_low", bus.out, SUBWORD ? 32'h0000_5678 : 32'h0);

        // Address wrap modulo 4 KiB
        drive(OP_SW, 32'h0000_1004, 32'h0000_0001);
        tick();
        drive(OP_LW, 32'h4, 32'h0);
        check("wrap_lw_4", bus.out, 32'h0000_0001);
        drive(OP_LW, 32'hFFFF_F004, 32'h0);
        check("wrap_lw_high", bus.out, 32'h0000_0001);

        // Non-memory opcodes: zero out, no write
        drive(OP_NOP, 32'h4, 32'h5555_5555);
        check("nop_out", bus.out, 32'h0);
        tick();
        drive(OP_SWL, 32'h4, 32'h6666_6666);
        check("swl_out", bus.out, 32'h0);
        tick();
        drive(OP_LW, 32'h4, 32'h0);
        check("lw_4_after_nonmem", bus.out, 32'h0000_0001);

        // Last word of the array
        drive(OP_SW, 32'hFFC, 32'hA5A5_0F0F);
        tick();
        drive(OP_LW, 32'hFFC, 32'h0);
        check("lw_last_word", bus.out, 32'hA5A5_0F0F);
        drive(OP_LW, 32'h4, 32'h0);
        check("lw_4_unchanged", bus.out, 32'h0000_0001);

        // Reset has priority over a concurrent store and clears everything
        rst = 1'b1;
        drive(OP_SW, 32'h20, 32'hFFFF_FFFF);
        tick();
        rst = 1'b0;
        drive(OP_LW, 32'h20, 32'h0);
        check("lw_20_after_rst", bus.out, 32'h0);
        drive(OP_LW, 32'h8, 32'h0);
        check("lw_8_after_rst", bus.out, 32'h0);
        drive(OP_LW, 32'hFFC, 32'h0);
        check("lw_last_after_rst", bus.out, 32'h0);

        // Store after reset, neighbour untouched
        drive(OP_SW, 32'h20, 32'hCAFE_F00D);
        tick();
        drive(OP_LW, 32'h20, 32'h0);
        check("lw_20_new", bus.out, 32'hCAFE_F00D);
        drive(OP_LW, 32'h24, 32'h0);
        check("lw_24_zero", bus.out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
